mem_port_scheduler: RTL and testbench
=====================================

MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requesters (index 0 = icache refill, 1 = dcache).
REQ-002 SHALL have parameter MaxOutstanding, default 7, maximum accepted-but-unanswered memory transactions.
REQ-003 SHALL have parameter AddrWidth, default 64, request address width.
REQ-004 SHALL have parameter DataWidth, default 64, write/read data width.
REQ-005 SHALL have parameter TidWidth, default 2, per-requester transaction ID width.
REQ-006 SHALL have ports, in this order:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset; synchronous, active-low.
- req_valid_i  in  NumReq  request pending.
- req_ready_o  out  NumReq  request accepted this cycle.
- req_addr_i  in  NumReq x AddrWidth  address.
- req_we_i  in  NumReq  1 = write.
- req_wdata_i  in  NumReq x DataWidth  write data.
- req_tid_i  in  NumReq x TidWidth  requester TID.
- mem_valid_o  out  1  memory request valid.
- mem_ready_i  in  1  memory accepts.
- mem_addr_o  out  AddrWidth  address.
- mem_we_o  out  1  write.
- mem_wdata_o  out  DataWidth  write data.
- mem_id_o  out  IdxW+TidWidth  {requester index, TID}; IdxW = max(1, clog2(NumReq)).
- mem_rsp_valid_i  in  1  response valid; always accepted.
- mem_rsp_id_i  in  IdxW+TidWidth  response ID.
- mem_rsp_rdata_i  in  DataWidth  read data.
- rsp_valid_o  out  NumReq  response for requester.
- rsp_tid_o  out  TidWidth  response TID.
- rsp_rdata_o  out  DataWidth  response data.
- flush_i  in  1  drain request (fence).
- flush_done_o  out  1  one-cycle drain-complete pulse.
- stall_cnt_o  out  32  outstanding-limit stall cycle count.

Function
REQ-007 SHALL select one requester per cycle by round-robin; pointer advances past the winner only on acceptance.
REQ-008 SHALL accept (req_ready_o high for winner only) when the output slot is empty or draining this cycle, the outstanding count plus slot occupancy is below MaxOutstanding, and the state is RUN.
REQ-009 SHALL register the accepted request into a one-entry output slot; mem_valid_o rises the cycle after acceptance (latency 1).
REQ-010 SHALL hold mem_* outputs stable while mem_valid_o=1 and mem_ready_i=0.
REQ-011 SHALL allow back-to-back throughput: slot handshake and new acceptance in the same cycle.
REQ-012 SHALL increment the outstanding count on mem handshake, decrement on mem_rsp_valid_i, and hold it unchanged when both occur.
REQ-013 SHALL route each response combinationally: rsp_valid_o[mem_rsp_id_i index] = mem_rsp_valid_i, rsp_tid_o/rsp_rdata_o pass-through.
REQ-014 SHALL implement states RUN, DRAIN, DONE: RUN->DRAIN on flush_i; DRAIN->DONE when slot empty and count 0; DONE->RUN unconditionally, with flush_done_o=1 only in DONE.
REQ-015 SHALL accept no new requests in DRAIN or DONE; a flush_i in DRAIN is absorbed.
REQ-016 SHALL treat a response with count 0 as a protocol error: count saturates at 0 (no wrap).

Reset
REQ-017 SHALL, on rst_ni=0 at a clock edge: slot empty, count 0, state RUN, RR pointer 0, stall_cnt_o 0; mem_valid_o, req_ready_o and flush_done_o low from the next cycle.
REQ-018 SHALL discard an in-flight slot and outstanding count on mid-operation reset without emitting a handshake.

Configuration
REQ-019 SHALL, with MEM_PORT_SCHED_STALL_CNT_EN defined, increment stall_cnt_o (wrapping at 2^32) every cycle any req_valid_i is high and acceptance is blocked solely by the outstanding limit.
REQ-020 SHALL, without MEM_PORT_SCHED_STALL_CNT_EN, tie stall_cnt_o to 0 and instantiate no counter.

Structure
REQ-021 SHALL place the state enum (RUN/DRAIN/DONE) and the IdxW computation in package mem_port_sched_pkg.
REQ-022 SHALL implement round-robin selection in sub-module mem_port_sched_rr (inputs valid vector and advance enable; outputs one-hot grant and index).

Verification
REQ-023 SHALL cover: both requesters valid for 4 cycles with mem_ready_i=1 -> grants 0,1,0,1, mem_id_o index bits alternate.
REQ-024 SHALL cover: 7 accepted requests with no responses -> 8th stalled, req_ready_o=0, stall_cnt_o increments per cycle (macro defined); one response -> next accepted.
REQ-025 SHALL cover: mem_ready_i=0 for 5 cycles -> mem_addr_o/mem_wdata_o/mem_id_o unchanged throughout.
REQ-026 SHALL cover: flush_i with 3 outstanding -> no acceptance; flush_done_o pulses exactly once, 1 cycle after 3rd response; then RUN resumes.
REQ-027 SHALL cover: response and handshake in the same cycle at count 4 -> count stays 4; rst_ni=0 mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_port_sched_pkg.sv
// mem_port_sched_pkg: scheduler state encoding and requester-index sizing
package mem_port_sched_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} sched_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_sched_rr.sv
// mem_port_sched_rr: round-robin picker; pointer moves past the winner only when it is accepted
module mem_port_sched_rr import mem_port_sched_pkg::*; #(
    parameter int NumReq = 2,
    parameter int IdxW   = idx_width(NumReq)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NumReq-1:0] valid,
    input  logic              advance,
    output logic [NumReq-1:0] grant,
    output logic [IdxW-1:0]   idx
);

    logic [IdxW-1:0] ptr;
    logic            found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            automatic int j = (int'(ptr) + i) % NumReq;
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IdxW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= '0;
        else if (advance)
            ptr <= (int'(idx) == NumReq - 1) ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: round-robin memory port with outstanding limit and fence drain;
// MEM_PORT_SCHED_STALL_CNT_EN adds a cycle counter of outstanding-limit stalls.
module mem_port_scheduler import mem_port_sched_pkg::*; #(
    parameter int NumReq         = 2,
    parameter int MaxOutstanding = 7,
    parameter int AddrWidth      = 64,
    parameter int DataWidth      = 64,
    parameter int TidWidth       = 2
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NumReq-1:0]                           req_valid_i,
    output logic [NumReq-1:0]                           req_ready_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]            req_addr_i,
    input  logic [NumReq-1:0]                           req_we_i,
    input  logic [NumReq-1:0][DataWidth-1:0]            req_wdata_i,
    input  logic [NumReq-1:0][TidWidth-1:0]             req_tid_i,
    output logic                                        mem_valid_o,
    input  logic                                        mem_ready_i,
    output logic [AddrWidth-1:0]                        mem_addr_o,
    output logic                                        mem_we_o,
    output logic [DataWidth-1:0]                        mem_wdata_o,
    output logic [idx_width(NumReq)+TidWidth-1:0]       mem_id_o,
    input  logic                                        mem_rsp_valid_i,
    input  logic [idx_width(NumReq)+TidWidth-1:0]       mem_rsp_id_i,
    input  logic [DataWidth-1:0]                        mem_rsp_rdata_i,
    output logic [NumReq-1:0]                           rsp_valid_o,
    output logic [TidWidth-1:0]                         rsp_tid_o,
    output logic [DataWidth-1:0]                        rsp_rdata_o,
    input  logic                                        flush_i,
    output logic                                        flush_done_o,
    output logic [31:0]                                 stall_cnt_o
);

    localparam int IdxW = idx_width(NumReq);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    sched_state_e    state;
    logic            slot_valid;
    logic            slot_nxt;
    logic [CntW-1:0] count;
    logic [CntW-1:0] count_nxt;
    logic [NumReq-1:0] grant;
    logic [IdxW-1:0] win;
    logic [IdxW-1:0] rsp_idx;
    logic            hs;
    logic            slot_free;
    logic            under_limit;
    logic            accept;
    logic            rsp_dec;

    mem_port_sched_rr #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .valid   (req_valid_i),
        .advance (accept),
        .grant   (grant),
        .idx     (win)
    );

    assign mem_valid_o = slot_valid;
    assign hs          = slot_valid && mem_ready_i;
    assign slot_free   = !slot_valid || mem_ready_i;
    // the slot counts against the limit because its handshake will raise count
    assign under_limit = int'(count) + int'(slot_valid) < MaxOutstanding;
    assign accept      = rst_ni && |req_valid_i && slot_free && under_limit && state == RUN;
    assign req_ready_o = accept ? grant : '0;
    assign slot_nxt    = accept || (slot_valid && !hs);
    // a response at count 0 is a protocol error and is not allowed to wrap the count
    assign rsp_dec     = mem_rsp_valid_i && count != '0;
    assign count_nxt   = (hs && !rsp_dec) ? count + 1'b1 :
                         (!hs && rsp_dec) ? count - 1'b1 : count;
    assign flush_done_o = state == DONE;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= RUN;
            slot_valid <= 1'b0;
            count      <= '0;
        end else begin
            slot_valid <= slot_nxt;
            count      <= count_nxt;
            state      <= (state == RUN && flush_i) ? DRAIN :
                          (state == DRAIN && !slot_nxt && count_nxt == '0) ? DONE :
                          (state == DONE) ? RUN : state;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_addr_o  <= req_addr_i[win];
            mem_we_o    <= req_we_i[win];
            mem_wdata_o <= req_wdata_i[win];
            mem_id_o    <= {win, req_tid_i[win]};
        end
    end

    assign rsp_idx     = mem_rsp_id_i[TidWidth +: IdxW];
    assign rsp_tid_o   = mem_rsp_id_i[TidWidth-1:0];
    assign rsp_rdata_o = mem_rsp_rdata_i;

    always_comb begin
        rsp_valid_o = '0;
        if (mem_rsp_valid_i && int'(rsp_idx) < NumReq)
            rsp_valid_o[rsp_idx] = 1'b1;
    end

`ifdef MEM_PORT_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            stall_cnt <= '0;
        else if (|req_valid_i && state == RUN && slot_free && !under_limit)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb_mem_port_scheduler: self-checking bench with response vector table and memory-request scoreboard
module tb_mem_port_scheduler;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic [2:0]  id;
    } mem_req_t;

    typedef struct {
        logic        v;
        logic [2:0]  id;
        logic [63:0] d;
        logic [1:0]  ev;
        logic [1:0]  et;
    } rsp_vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0][63:0] req_addr = '0;
    logic [1:0]       req_we = '0;
    logic [1:0][63:0] req_wdata = '0;
    logic [1:0][1:0]  req_tid = '0;
    logic             mem_valid;
    logic             mem_ready = 1'b1;
    logic [63:0]      mem_addr;
    logic             mem_we;
    logic [63:0]      mem_wdata;
    logic [2:0]       mem_id;
    logic             mem_rsp_valid = 1'b0;
    logic [2:0]       mem_rsp_id = '0;
    logic [63:0]      mem_rsp_rdata = '0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_tid;
    logic [63:0]      rsp_rdata;
    logic             flush = 1'b0;
    logic             flush_done;
    logic [31:0]      stall_cnt;

    int total = 0;
    int bad = 0;
    int exp_stall = 0;
    int seq = 0;
    mem_req_t sb[$];
    rsp_vec_t tbl[6];

    always #5 clk = ~clk;

    mem_port_scheduler dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .req_we_i        (req_we),
        .req_wdata_i     (req_wdata),
        .req_tid_i       (req_tid),
        .mem_valid_o     (mem_valid),
        .mem_ready_i     (mem_ready),
        .mem_addr_o      (mem_addr),
        .mem_we_o        (mem_we),
        .mem_wdata_o     (mem_wdata),
        .mem_id_o        (mem_id),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_id_i    (mem_rsp_id),
        .mem_rsp_rdata_i (mem_rsp_rdata),
        .rsp_valid_o     (rsp_valid),
        .rsp_tid_o       (rsp_tid),
        .rsp_rdata_o     (rsp_rdata),
        .flush_i         (flush),
        .flush_done_o    (flush_done),
        .stall_cnt_o     (stall_cnt)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stall();
`ifdef MEM_PORT_SCHED_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 64'(exp_stall));
`else
        check("stall_cnt", stall_cnt, 64'd0);
`endif
    endtask

    task automatic set_req(input int r);
        seq++;
        req_valid[r] = 1'b1;
        req_addr[r]  = 64'(seq) * 64'h1000 + 64'(r);
        req_wdata[r] = {32'(seq), 32'hC0DE_0000 | 32'(r)};
        req_we[r]    = seq[0];
        req_tid[r]   = seq[2:1];
    endtask

    function automatic mem_req_t exp_of(input int r);
        mem_req_t e;
        e.addr  = req_addr[r];
        e.wdata = req_wdata[r];
        e.we    = req_we[r];
        e.id    = {r[0], req_tid[r]};
        return e;
    endfunction

    // single requester streams for n cycles; accepts expected for k < n_acc and right after a response
    task automatic run_req(input int r, input int n, input int n_acc, input int rsp_at);
        for (int k = 0; k < n; k++) begin
            logic acc;
            req_valid     = '0;
            set_req(r);
            mem_rsp_valid = (k == rsp_at);
            mem_rsp_id    = {r[0], 2'b00};
            acc           = (k < n_acc) || (k == rsp_at + 1);
            #1;
            check("ready", {62'd0, req_ready}, acc ? (64'd1 << r) : 64'd0);
            check_stall();
            if (acc)
                sb.push_back(exp_of(r));
            else
                exp_stall++;
            cyc();
        end
        req_valid     = '0;
        mem_rsp_valid = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic drain_rsp(input int n, input int r);
        for (int k = 0; k < n; k++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_id    = {r[0], k[1:0]};
            mem_rsp_rdata = 64'(k) + 64'hD00;
            #1;
            check("rsp_route", {62'd0, rsp_valid}, 64'd1 << r);
            check("rsp_tid", {62'd0, rsp_tid}, {62'd0, k[1:0]});
            cyc();
        end
        mem_rsp_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && mem_valid && mem_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mem_hs: got unexpected handshake addr %0h expected none", mem_addr);
            end else begin
                mem_req_t e;
                e = sb.pop_front();
                check("mem_addr", mem_addr, e.addr);
                check("mem_wdata", mem_wdata, e.wdata);
                check("mem_we", {63'd0, mem_we}, {63'd0, e.we});
                check("mem_id", {61'd0, mem_id}, {61'd0, e.id});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        mem_req_t held;
        tbl[0] = '{1'b1, 3'b001, 64'hAAAA_0001, 2'b01, 2'd1};
        tbl[1] = '{1'b1, 3'b110, 64'hBBBB_0002, 2'b10, 2'd2};
        tbl[2] = '{1'b0, 3'b101, 64'hCCCC_0003, 2'b00, 2'd1};
        tbl[3] = '{1'b1, 3'b100, 64'hDDDD_0004, 2'b10, 2'd0};
        tbl[4] = '{1'b1, 3'b011, 64'hEEEE_0005, 2'b01, 2'd3};
        tbl[5] = '{1'b1, 3'b000, 64'hFFFF_0006, 2'b01, 2'd0};

        cyc();
        cyc();
        check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        check("rst_ready", {62'd0, req_ready}, 64'd0);
        check("rst_flush_done", {63'd0, flush_done}, 64'd0);
        check("rst_stall", {32'd0, stall_cnt}, 64'd0);
        rst_n = 1'b1;
        cyc();

        for (int c = 0; c < 4; c++) begin
            req_valid = '0;
            set_req(0);
            set_req(1);
            #1;
            check("rr_grant", {62'd0, req_ready}, (c % 2 == 0) ? 64'd1 : 64'd2);
            sb.push_back(exp_of(c % 2));
            cyc();
        end
        req_valid = '0;
        cyc();
        cyc();

        // four outstanding, then five responses: the fifth hits count 0 and must saturate
        for (int i = 0; i < 6; i++) begin
            mem_rsp_valid = tbl[i].v;
            mem_rsp_id    = tbl[i].id;
            mem_rsp_rdata = tbl[i].d;
            #1;
            check("tbl_rsp_valid", {62'd0, rsp_valid}, {62'd0, tbl[i].ev});
            check("tbl_rsp_tid", {62'd0, rsp_tid}, {62'd0, tbl[i].et});
            check("tbl_rsp_rdata", rsp_rdata, tbl[i].d);
            cyc();
        end
        mem_rsp_valid = 1'b0;

        run_req(0, 12, 7, 10);
        drain_rsp(5, 0);

        mem_ready = 1'b0;
        req_valid = '0;
        set_req(1);
        #1;
        check("hold_accept", {62'd0, req_ready}, 64'd2);
        held = exp_of(1);
        sb.push_back(held);
        cyc();
        for (int h = 0; h < 5; h++) begin
            set_req(1);
            req_valid = '0;
            #1;
            check("hold_valid", {63'd0, mem_valid}, 64'd1);
            check("hold_addr", mem_addr, held.addr);
            check("hold_wdata", mem_wdata, held.wdata);
            check("hold_id", {61'd0, mem_id}, {61'd0, held.id});
            cyc();
        end

        rst_n = 1'b0;
        set_req(1);
        #1;
        check("mid_rst_ready", {62'd0, req_ready}, 64'd0);
        cyc();
        check("mid_rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        check("mid_rst_ready2", {62'd0, req_ready}, 64'd0);
        check("mid_rst_flush_done", {63'd0, flush_done}, 64'd0);
        check("mid_rst_stall", {32'd0, stall_cnt}, 64'd0);
        rst_n     = 1'b1;
        req_valid = '0;
        mem_ready = 1'b1;
        sb.delete();
        exp_stall = 0;
        cyc();

        run_req(0, 9, 7, -1);
        drain_rsp(7, 0);

        run_req(1, 3, 3, -1);
        for (int f = 0; f < 8; f++) begin
            req_valid = '0;
            if (f >= 1)
                set_req(0);
            flush         = (f < 2);
            mem_rsp_valid = (f == 2 || f == 4 || f == 5);
            mem_rsp_id    = {1'b1, 2'(f)};
            #1;
            check("flush_ready", {62'd0, req_ready}, (f == 7) ? 64'd1 : 64'd0);
            check("flush_done", {63'd0, flush_done}, {63'd0, f == 6});
            if (f == 7)
                sb.push_back(exp_of(0));
            cyc();
        end
        req_valid     = '0;
        flush         = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        check("flush_done_after", {63'd0, flush_done}, 64'd0);
        cyc();
        drain_rsp(1, 0);

        run_req(0, 9, 8, 5);
        cyc();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
